// File: rtl/pc_ir_unit.sv
// pc_ir_unit: PC / OldPC / instruction / memory-data register stage behind the
// multicycle control FSM. It evaluates RV32I branch conditions from the ALU flags
// and stops the core in a sticky halt state on a misaligned PC target.
// Optional macro FETCH_CNT_EN adds a 32-bit count of fetched instructions.
// Without it, FetchCount is tied to zero.
module pc_ir_unit #(
   parameter int unsigned       XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            PCUpdate,
   input  logic            Branch,
   input  logic            IRWrite,
   input  logic [XLEN-1:0] Result,
   input  logic [XLEN-1:0] ReadData,
   input  logic            Zero,
   input  logic            Negative,
   input  logic            Carry,
   input  logic            Overflow,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] OldPC,
   output logic [XLEN-1:0] Instr,
   output logic [XLEN-1:0] Data,
   output logic            PCWrite,
   output logic            TakeBranch,
   output logic            Halted,
   output logic [XLEN-1:0] FaultPC,
   output logic [31:0]     FetchCount
);

   typedef enum logic {StRun, StHalt} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, old_pc_q, instr_q, data_q, fault_pc_q;
   logic [2:0]      funct3;
   logic            misaligned;
   logic            ir_load;

   assign funct3     = instr_q[14:12];
   assign misaligned = (Result[1:0] != 2'b00);
   assign Halted     = (state_q == StHalt);
   assign PCWrite    = (PCUpdate | (Branch & TakeBranch)) & ~Halted;
   assign ir_load    = IRWrite & ~Halted;

   // Branch condition decode from funct3 and the ALU flags
   always_comb begin
      TakeBranch = 1'b0;
      case (funct3)
         3'b000:  TakeBranch = Zero;
         3'b001:  TakeBranch = ~Zero;
         3'b100:  TakeBranch = Negative ^ Overflow;
         3'b101:  TakeBranch = ~(Negative ^ Overflow);
         3'b110:  TakeBranch = ~Carry;
         3'b111:  TakeBranch = Carry;
         default: TakeBranch = 1'b0;
      endcase
   end

   // Next state: a misaligned PC write in RUN halts until reset
   always_comb begin
      state_d = state_q;
      if (state_q == StRun && PCWrite && misaligned) begin
         state_d = StHalt;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // PC and fault capture; PCWrite is already zero while halted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         fault_pc_q <= '0;
      end else if (PCWrite) begin
         if (misaligned) begin
            fault_pc_q <= Result;
         end else begin
            pc_q <= Result;
         end
      end
   end

   // Instruction register and OldPC; OldPC takes the pre-update PC
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_q  <= XLEN'(32'h0000_0013);
         old_pc_q <= RESET_PC;
      end else if (ir_load) begin
         instr_q  <= ReadData;
         old_pc_q <= pc_q;
      end
   end

   // Memory data register tracks ReadData every cycle, even when halted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= '0;
      end else begin
         data_q <= ReadData;
      end
   end

`ifdef FETCH_CNT_EN
   logic [31:0] fetch_cnt_q;

   // Fetch counter, wraps naturally at 2^32
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt_q <= '0;
      end else if (ir_load) begin
         fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
   end

   assign FetchCount = fetch_cnt_q;
`else
   assign FetchCount = 32'd0;
`endif

   assign PC      = pc_q;
   assign OldPC   = old_pc_q;
   assign Instr   = instr_q;
   assign Data    = data_q;
   assign FaultPC = fault_pc_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed testbench for pc_ir_unit: reset values, fetch, branch decode, misalign
// halt, asynchronous reset out of halt and the optional fetch counter.
module tb_pc_ir_unit;

   logic        clk;
   logic        reset;
   logic        PCUpdate, Branch, IRWrite;
   logic [31:0] Result, ReadData;
   logic        Zero, Negative, Carry, Overflow;
   logic [31:0] PC, OldPC, Instr, Data, FaultPC, FetchCount;
   logic        PCWrite, TakeBranch, Halted;

   int n_checks = 0;
   int n_fail   = 0;
   int unsigned fc = 0;

   pc_ir_unit dut (
      .clk        (clk),
      .reset      (reset),
      .PCUpdate   (PCUpdate),
      .Branch     (Branch),
      .IRWrite    (IRWrite),
      .Result     (Result),
      .ReadData   (ReadData),
      .Zero       (Zero),
      .Negative   (Negative),
      .Carry      (Carry),
      .Overflow   (Overflow),
      .PC         (PC),
      .OldPC      (OldPC),
      .Instr      (Instr),
      .Data       (Data),
      .PCWrite    (PCWrite),
      .TakeBranch (TakeBranch),
      .Halted     (Halted),
      .FaultPC    (FaultPC),
      .FetchCount (FetchCount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_fc();
`ifdef FETCH_CNT_EN
      return fc;
`else
      return 32'd0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load a branch-format instruction with the given funct3 (no PC write)
   task automatic load_instr(input logic [2:0] f3);
      logic [31:0] word;
      word     = 32'h0000_0063 | {17'b0, f3, 12'b0};
      IRWrite  = 1'b1;
      ReadData = word;
      tick();
      IRWrite = 1'b0;
      fc++;
      check("load_instr", Instr, word);
   endtask

   // funct3 100,101,110,111 against (N,V,C) = (1,0,0), (0,0,1), (1,1,1)
   logic [2:0] sweep_f3 [4];
   logic [2:0] sweep_nvc [3];
   logic       sweep_exp [4][3];

   initial begin
      sweep_f3  = '{3'b100, 3'b101, 3'b110, 3'b111};
      sweep_nvc = '{3'b100, 3'b001, 3'b111};
      sweep_exp = '{'{1'b1, 1'b0, 1'b0},
                    '{1'b0, 1'b1, 1'b1},
                    '{1'b1, 1'b0, 1'b0},
                    '{1'b0, 1'b1, 1'b1}};

      reset = 1'b1;
      PCUpdate = 1'b0; Branch = 1'b0; IRWrite = 1'b0;
      Result = '0; ReadData = '0;
      Zero = 1'b0; Negative = 1'b0; Carry = 1'b0; Overflow = 1'b0;

      // Reset values, applied asynchronously before the first edge
      #2 reset = 1'b0;
      #1;
      check("rst_pc", PC, 32'h0);
      check("rst_oldpc", OldPC, 32'h0);
      check("rst_instr", Instr, 32'h13);
      check("rst_data", Data, 32'h0);
      check("rst_faultpc", FaultPC, 32'h0);
      check("rst_fetchcnt", FetchCount, 32'h0);
      check1("rst_halted", Halted, 1'b0);
      check1("rst_pcwrite", PCWrite, 1'b0);
      tick();
      tick();
      reset = 1'b1;

      // First fetch with concurrent PC update
      IRWrite = 1'b1; PCUpdate = 1'b1; ReadData = 32'h0050_0093; Result = 32'h4;
      #1;
      check1("fetch_pcwrite", PCWrite, 1'b1);
      tick();
      fc++;
      check("fetch_pc", PC, 32'h4);
      check("fetch_oldpc", OldPC, 32'h0);
      check("fetch_instr", Instr, 32'h0050_0093);
      check("fetch_data", Data, 32'h0050_0093);
      check("fetch_cnt", FetchCount, exp_fc());

      // beq taken (funct3 000 from the addi just loaded)
      IRWrite = 1'b0; PCUpdate = 1'b0; Branch = 1'b1; Zero = 1'b1; Result = 32'h40;
      #1;
      check1("beq_take", TakeBranch, 1'b1);
      check1("beq_pcwrite", PCWrite, 1'b1);
      tick();
      check("beq_pc", PC, 32'h40);

      // beq not taken
      Zero = 1'b0; Result = 32'h80;
      #1;
      check1("beq_nt_take", TakeBranch, 1'b0);
      check1("beq_nt_pcwrite", PCWrite, 1'b0);
      tick();
      check("beq_nt_pc", PC, 32'h40);
      Branch = 1'b0;

      // Signed/unsigned compare sweep
      for (int f = 0; f < 4; f++) begin
         load_instr(sweep_f3[f]);
         for (int c = 0; c < 3; c++) begin
            {Negative, Overflow, Carry} = sweep_nvc[c];
            #1;
            check1($sformatf("br_f%0b_nvc%0b", sweep_f3[f], sweep_nvc[c]),
                   TakeBranch, sweep_exp[f][c]);
         end
      end
      check("sweep_oldpc", OldPC, 32'h40);
      check("sweep_cnt", FetchCount, exp_fc());

      // bne both ways, then the reserved 010/011 encodings
      load_instr(3'b001);
      Zero = 1'b0; #1;
      check1("bne_take", TakeBranch, 1'b1);
      Zero = 1'b1; #1;
      check1("bne_nt", TakeBranch, 1'b0);
      load_instr(3'b010);
      Negative = 1'b1; Overflow = 1'b0; Carry = 1'b1; Zero = 1'b1; #1;
      check1("f010_take", TakeBranch, 1'b0);
      load_instr(3'b011);
      check1("f011_take", TakeBranch, 1'b0);

      // Misaligned target with a concurrent fetch: IR still loads, then halt
      PCUpdate = 1'b1; Result = 32'h46; IRWrite = 1'b1; ReadData = 32'hABCD_0013;
      tick();
      fc++;
      check("mis_pc", PC, 32'h40);
      check("mis_faultpc", FaultPC, 32'h46);
      check1("mis_halted", Halted, 1'b1);
      check("mis_instr", Instr, 32'hABCD_0013);
      check1("mis_pcwrite", PCWrite, 1'b0);

      // Halted: writes ignored, Data keeps tracking
      Result = 32'h47; ReadData = 32'h1234_5678; Branch = 1'b1;
      tick();
      Result = 32'h100; ReadData = 32'h8765_4321;
      tick();
      check("halt_pc", PC, 32'h40);
      check("halt_faultpc", FaultPC, 32'h46);
      check("halt_instr", Instr, 32'hABCD_0013);
      check("halt_oldpc", OldPC, 32'h40);
      check("halt_data", Data, 32'h8765_4321);
      check("halt_cnt", FetchCount, exp_fc());
      check1("halt_halted", Halted, 1'b1);

      // Asynchronous reset mid-cycle, no clock edge before the check
      #2 reset = 1'b0;
      #1;
      check("areset_pc", PC, 32'h0);
      check("areset_instr", Instr, 32'h13);
      check("areset_faultpc", FaultPC, 32'h0);
      check("areset_data", Data, 32'h0);
      check("areset_cnt", FetchCount, 32'h0);
      check1("areset_halted", Halted, 1'b0);
      fc = 0;

      // Counter after reset release
      PCUpdate = 1'b0; Branch = 1'b0; IRWrite = 1'b0;
      tick();
      reset = 1'b1;
      load_instr(3'b000);
      check("post_cnt", FetchCount, exp_fc());
      check("post_oldpc", OldPC, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
